// File: rtl/sauria_axi4_lite_pkg.sv
// Shared AXI4-Lite response codes, channel records and FSM state types for the
// SAURIA register slave.
package sauria_axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic                  valid;
    } aw_chan_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0]   data;
        logic [AXI_DATA_W/8-1:0] strb;
        logic                    valid;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
        logic       valid;
    } b_chan_t;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic                  valid;
    } ar_chan_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  valid;
    } r_chan_t;

    typedef enum logic [1:0] {WrIdle, WrHaveAw, WrHaveW, WrResp} wr_state_e;
    typedef enum logic {RdIdle, RdResp} rd_state_e;

endpackage

// File: rtl/sauria_axi4_lite_wr_ctrl.sv
// Write-side FSM: pairs AW and W in either order, decodes the target and emits a
// one-cycle commit strobe with index, data and byte strobes.
module sauria_axi4_lite_wr_ctrl
    import sauria_axi4_lite_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 32,
    localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_awaddr,
    input  logic              i_awvalid,
    output logic              o_awready,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_wstrb,
    input  logic              i_wvalid,
    output logic              o_wready,
    output logic [1:0]        o_bresp,
    output logic              o_bvalid,
    input  logic              i_bready,
    output logic              o_commit,
    output logic [IDX_W-1:0]  o_commit_idx,
    output logic [31:0]       o_commit_data,
    output logic [3:0]        o_commit_strb
);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-3:0] addr_q;
    logic [31:0]       data_q;
    logic [3:0]        strb_q;
    logic [1:0]        bresp_q, bresp_d;
    logic              aw_hs, w_hs, complete, in_range, writable;
    logic [ADDR_W-3:0] eff_addr;
    logic              unused_awaddr;

    assign unused_awaddr = ^i_awaddr[1:0];

    always_comb begin
        o_awready = (state_q == WrIdle) || (state_q == WrHaveW);
        o_wready  = (state_q == WrIdle) || (state_q == WrHaveAw);
        aw_hs     = i_awvalid && o_awready;
        w_hs      = i_wvalid && o_wready;
        state_d   = state_q;
        complete  = 1'b0;
        unique case (state_q)
            WrIdle: begin
                if (aw_hs && w_hs) begin
                    complete = 1'b1;
                    state_d  = WrResp;
                end else if (aw_hs) begin
                    state_d = WrHaveAw;
                end else if (w_hs) begin
                    state_d = WrHaveW;
                end
            end
            WrHaveAw: if (w_hs) begin
                complete = 1'b1;
                state_d  = WrResp;
            end
            WrHaveW: if (aw_hs) begin
                complete = 1'b1;
                state_d  = WrResp;
            end
            WrResp: if (i_bready) state_d = WrIdle;
            default: state_d = WrIdle;
        endcase

        // Whichever half arrived earlier comes from its latch, the other from the bus.
        eff_addr      = (state_q == WrHaveAw) ? addr_q : i_awaddr[ADDR_W-1:2];
        o_commit_data = (state_q == WrHaveW) ? data_q : i_wdata;
        o_commit_strb = (state_q == WrHaveW) ? strb_q : i_wstrb;
        in_range      = (eff_addr >> IDX_W) == '0;
        o_commit_idx  = eff_addr[IDX_W-1:0];
        writable      = in_range && (o_commit_idx != '0);
        o_commit      = complete && writable;
        bresp_d       = bresp_q;
        if (complete) bresp_d = writable ? RESP_OKAY : RESP_SLVERR;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= WrIdle;
            bresp_q <= RESP_OKAY;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            bresp_q <= bresp_d;
            if (aw_hs) addr_q <= i_awaddr[ADDR_W-1:2];
            if (w_hs) begin
                data_q <= i_wdata;
                strb_q <= i_wstrb;
            end
        end
    end

    assign o_bvalid = (state_q == WrResp);
    assign o_bresp  = bresp_q;

endmodule

// File: rtl/sauria_axi4_lite_reg_slave.sv
// AXI4-Lite responder over a bank of 32-bit config registers; reg 0 is a fixed ID
// and the whole bank is exported flat on o_regs.
module sauria_axi4_lite_reg_slave
    import sauria_axi4_lite_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] ID_VALUE = 32'h5A55_0001
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [ADDR_W-1:0]      i_awaddr,
    input  logic                   i_awvalid,
    output logic                   o_awready,
    input  logic [31:0]            i_wdata,
    input  logic [3:0]             i_wstrb,
    input  logic                   i_wvalid,
    output logic                   o_wready,
    output logic [1:0]             o_bresp,
    output logic                   o_bvalid,
    input  logic                   i_bready,
    input  logic [ADDR_W-1:0]      i_araddr,
    input  logic                   i_arvalid,
    output logic                   o_arready,
    output logic [31:0]            o_rdata,
    output logic [1:0]             o_rresp,
    output logic                   o_rvalid,
    input  logic                   i_rready,
    output logic [NUM_REGS*32-1:0] o_regs
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic [31:0]      regs_q [NUM_REGS];
    logic             commit;
    logic [IDX_W-1:0] commit_idx;
    logic [31:0]      commit_data;
    logic [3:0]       commit_strb;

    sauria_axi4_lite_wr_ctrl #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_wr_ctrl (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_awaddr      (i_awaddr),
        .i_awvalid     (i_awvalid),
        .o_awready     (o_awready),
        .i_wdata       (i_wdata),
        .i_wstrb       (i_wstrb),
        .i_wvalid      (i_wvalid),
        .o_wready      (o_wready),
        .o_bresp       (o_bresp),
        .o_bvalid      (o_bvalid),
        .i_bready      (i_bready),
        .o_commit      (commit),
        .o_commit_idx  (commit_idx),
        .o_commit_data (commit_data),
        .o_commit_strb (commit_strb)
    );

    // Reg 0 never sees a commit, so it holds ID_VALUE from reset onward.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= (k == 0) ? ID_VALUE : '0;
        end else if (commit) begin
            for (int j = 0; j < 4; j++) begin
                if (commit_strb[j]) regs_q[commit_idx][8*j +: 8] <= commit_data[8*j +: 8];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) o_regs[32*k +: 32] = regs_q[k];
    end

    rd_state_e        rd_state_q, rd_state_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;
    logic             ar_hs, ar_in_range;
    logic [IDX_W-1:0] ar_idx;
    logic             unused_araddr;

    assign unused_araddr = ^i_araddr[1:0];

    always_comb begin
        o_arready   = (rd_state_q == RdIdle);
        ar_hs       = i_arvalid && o_arready;
        ar_in_range = (i_araddr[ADDR_W-1:2] >> IDX_W) == '0;
        ar_idx      = i_araddr[2 +: IDX_W];
        rd_state_d  = rd_state_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        unique case (rd_state_q)
            RdIdle: if (ar_hs) begin
                rd_state_d = RdResp;
                // regs_q is pre-commit here, so a same-edge write is not visible.
                rdata_d    = ar_in_range ? regs_q[ar_idx] : '0;
                rresp_d    = ar_in_range ? RESP_OKAY : RESP_SLVERR;
            end
            RdResp: if (i_rready) rd_state_d = RdIdle;
            default: rd_state_d = RdIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_state_q <= RdIdle;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign o_rvalid = (rd_state_q == RdResp);
    assign o_rdata  = rdata_q;
    assign o_rresp  = rresp_q;

endmodule

// File: tb/tb_sauria_axi4_lite_reg_slave.sv
// Self-checking bench: vector table plus hand-written corner sequences, with
// B and R responses checked against expectation queues.
module tb_sauria_axi4_lite_reg_slave;
    import sauria_axi4_lite_pkg::*;

    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned ADDR_W   = 32;
    localparam logic [31:0] ID       = 32'h5A55_0001;

    logic                   clk, rst;
    logic [ADDR_W-1:0]      awaddr, araddr;
    logic                   awvalid, awready, wvalid, wready, bvalid, bready;
    logic                   arvalid, arready, rvalid, rready;
    logic [31:0]            wdata, rdata;
    logic [3:0]             wstrb;
    logic [1:0]             bresp, rresp;
    logic [NUM_REGS*32-1:0] regs;

    sauria_axi4_lite_reg_slave dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_awaddr  (awaddr),
        .i_awvalid (awvalid),
        .o_awready (awready),
        .i_wdata   (wdata),
        .i_wstrb   (wstrb),
        .i_wvalid  (wvalid),
        .o_wready  (wready),
        .o_bresp   (bresp),
        .o_bvalid  (bvalid),
        .i_bready  (bready),
        .i_araddr  (araddr),
        .i_arvalid (arvalid),
        .o_arready (arready),
        .o_rdata   (rdata),
        .o_rresp   (rresp),
        .o_rvalid  (rvalid),
        .i_rready  (rready),
        .o_regs    (regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    logic [1:0] wq[$];
    rexp_t      rq[$];
    logic [1:0] b_exp;
    rexp_t      r_exp;
    vec_t       vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Responses are compared on the negedge before the handshake edge.
    always @(negedge clk) begin
        if (!rst && bvalid && bready) begin
            if (wq.size() == 0) begin
                check("b_unexpected", 32'd1, 32'd0);
            end else begin
                b_exp = wq.pop_front();
                check("bresp", {30'd0, bresp}, {30'd0, b_exp});
            end
        end
        if (!rst && rvalid && rready) begin
            if (rq.size() == 0) begin
                check("r_unexpected", 32'd1, 32'd0);
            end else begin
                r_exp = rq.pop_front();
                check("rdata", rdata, r_exp.data);
                check("rresp", {30'd0, rresp}, {30'd0, r_exp.resp});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits until every asserted valid sees its ready, then completes that edge.
    task automatic handshake(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((!awvalid || awready) && (!wvalid || wready) && (!arvalid || arready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (wq.size() == 0 && rq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check({name, "_drain_timeout"}, wq.size() + rq.size(), 32'd0);
            wq.delete();
            rq.delete();
        end
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] resp, input string name);
        wq.push_back(resp);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        handshake(name);
        check({name, "_bvalid_next"}, {31'd0, bvalid}, 32'd1);
        wait_drain(name);
    endtask

    task automatic read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                        input string name);
        rq.push_back('{data: d, resp: resp});
        araddr  = a;
        arvalid = 1'b1;
        handshake(name);
        check({name, "_rvalid_next"}, {31'd0, rvalid}, 32'd1);
        wait_drain(name);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_bvalid"}, {31'd0, bvalid}, 32'd0);
        check({name, "_rvalid"}, {31'd0, rvalid}, 32'd0);
        check({name, "_awready"}, {31'd0, awready}, 32'd1);
        check({name, "_wready"}, {31'd0, wready}, 32'd1);
        check({name, "_arready"}, {31'd0, arready}, 32'd1);
        check({name, "_reg0"}, regs[31:0], ID);
        for (int k = 1; k < NUM_REGS; k++) check($sformatf("%s_reg%0d", name, k),
                                                 regs[32*k +: 32], 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, RESP_OKAY,   32'h0};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, RESP_OKAY,   32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h08, 32'h11223344, 4'hF, RESP_OKAY,   32'h0};
        vecs[3]  = '{1'b1, 32'h08, 32'hAABBCCDD, 4'h5, RESP_OKAY,   32'h0};
        vecs[4]  = '{1'b0, 32'h08, 32'h0,        4'h0, RESP_OKAY,   32'h11BB33DD};
        vecs[5]  = '{1'b1, 32'h00, 32'hFFFFFFFF, 4'hF, RESP_SLVERR, 32'h0};
        vecs[6]  = '{1'b0, 32'h00, 32'h0,        4'h0, RESP_OKAY,   ID};
        vecs[7]  = '{1'b0, 32'h40, 32'h0,        4'h0, RESP_SLVERR, 32'h0};
        vecs[8]  = '{1'b1, 32'h40, 32'h01020304, 4'hF, RESP_SLVERR, 32'h0};
        vecs[9]  = '{1'b1, 32'h3D, 32'h12345678, 4'h0, RESP_OKAY,   32'h0};
        vecs[10] = '{1'b0, 32'h3C, 32'h0,        4'h0, RESP_OKAY,   32'h0};
        vecs[11] = '{1'b1, 32'h3F, 32'h0000CAFE, 4'h3, RESP_OKAY,   32'h0};
        vecs[12] = '{1'b0, 32'h3E, 32'h0,        4'h0, RESP_OKAY,   32'h0000CAFE};
        vecs[13] = '{1'b0, 32'h7FFFFFFC, 32'h0,  4'h0, RESP_SLVERR, 32'h0};

        rst = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        bready = 1'b1; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("rst");
        check("rst_bresp", {30'd0, bresp}, 32'd0);
        check("rst_rresp", {30'd0, rresp}, 32'd0);
        check("rst_rdata", rdata, 32'd0);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp,
                                  $sformatf("vec%0d", i));
            else read(vecs[i].addr, vecs[i].rdata, vecs[i].resp, $sformatf("vec%0d", i));
        end
        check("img_reg0", regs[31:0], ID);
        check("img_reg1", regs[63:32], 32'hDEADBEEF);
        check("img_reg2", regs[95:64], 32'h11BB33DD);
        check("img_reg15", regs[511:480], 32'h0000CAFE);

        // W arrives three cycles before AW.
        wq.push_back(RESP_OKAY);
        wdata = 32'h0F0F0F0F; wstrb = 4'hF; wvalid = 1'b1;
        handshake("wfirst_w");
        check("wfirst_wready_low", {31'd0, wready}, 32'd0);
        check("wfirst_awready", {31'd0, awready}, 32'd1);
        step(); step();
        check("wfirst_no_bvalid", {31'd0, bvalid}, 32'd0);
        check("wfirst_reg2_old", regs[95:64], 32'h11BB33DD);
        awaddr = 32'h08; awvalid = 1'b1;
        handshake("wfirst_aw");
        check("wfirst_bvalid", {31'd0, bvalid}, 32'd1);
        check("wfirst_reg2_new", regs[95:64], 32'h0F0F0F0F);
        wait_drain("wfirst");

        // Same-edge read and write of reg 3 under response backpressure.
        write(32'h0C, 32'h12345678, 4'hF, RESP_OKAY, "coll_pre");
        bready = 1'b0; rready = 1'b0;
        wq.push_back(RESP_OKAY);
        rq.push_back('{data: 32'h12345678, resp: RESP_OKAY});
        awaddr = 32'h0C; wdata = 32'h9ABCDEF0; wstrb = 4'hF; araddr = 32'h0C;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        handshake("coll");
        for (int c = 0; c < 5; c++) begin
            check($sformatf("coll%0d_bvalid", c), {31'd0, bvalid}, 32'd1);
            check($sformatf("coll%0d_rvalid", c), {31'd0, rvalid}, 32'd1);
            check($sformatf("coll%0d_awready", c), {31'd0, awready}, 32'd0);
            check($sformatf("coll%0d_arready", c), {31'd0, arready}, 32'd0);
            check($sformatf("coll%0d_rdata", c), rdata, 32'h12345678);
            check($sformatf("coll%0d_bresp", c), {30'd0, bresp}, 32'd0);
            step();
        end
        check("coll_reg3", regs[127:96], 32'h9ABCDEF0);
        bready = 1'b1; rready = 1'b1;
        wait_drain("coll");
        read(32'h0C, 32'h9ABCDEF0, RESP_OKAY, "coll_post");

        // Reset while the write side holds an AW and the read side holds a response.
        awaddr = 32'h10; awvalid = 1'b1;
        araddr = 32'h14; arvalid = 1'b1;
        rready = 1'b0;
        handshake("mid");
        check("mid_have_aw", {30'd0, awready, wready}, 32'd1);
        check("mid_rvalid", {31'd0, rvalid}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rready = 1'b1;
        check_reset_state("mid_rst");
        read(32'h04, 32'h0, RESP_OKAY, "post_rst_rd");
        write(32'h10, 32'hA5A5A5A5, 4'hF, RESP_OKAY, "post_rst_wr");
        read(32'h10, 32'hA5A5A5A5, RESP_OKAY, "post_rst_rd2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
